// File: rtl/shift_tx_ctrl.sv
// Parallel-to-serial transmit controller: accepts a WIDTH-bit word, shifts it
// out MSB first with each bit held DIV clocks, then idles GAP bit periods.
module shift_tx_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             so,
  output logic             frame,
  output logic             done,
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for a word, in_ready high, so/frame low
  // SHIFT | frame bits on so, each bit held DIV cycles
  // GAPW  | inter-frame idle for GAP*DIV cycles
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAPW  = 2'd2
  } state_t;

  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W   = $clog2(WIDTH);
  localparam int GAP_CYC = GAP * DIV;
  localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam bit               HAS_GAP  = (GAP > 0);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sr_q,    sr_d;
  logic [BIT_W-1:0]   bit_q,   bit_d;
  logic [DIV_W-1:0]   div_q,   div_d;
  logic [GAP_W-1:0]   gap_q,   gap_d;
  logic               done_q,  done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    div_d   = div_q;
    gap_d   = gap_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sr_d    = in_data;
          bit_d   = '0;
          div_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          sr_d  = {sr_q[WIDTH-2:0], 1'b0};
          bit_d = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
            // done lands in the first cycle after the last bit period
            done_d  = 1'b1;
            bit_d   = '0;
            gap_d   = GAP_LOAD;
            state_d = HAS_GAP ? GAPW : IDLE;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      GAPW: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign frame    = (state_q == SHIFT);
  assign so       = (state_q == SHIFT) ? sr_q[WIDTH-1] : 1'b0;
  assign done     = done_q;

endmodule

// File: tb/tb_shift_tx_ctrl.sv
// Randomized scoreboard bench: two instances (DIV=2/GAP=1 and DIV=1/GAP=0)
// checked against a frame-level model of timing and serialized bits.
module tb_shift_tx_ctrl;
  localparam int W = 8;

  function automatic int dv(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic int gp(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]   rst_v;
  logic [1:0]   vld;
  logic [W-1:0] dat [2];
  wire  [1:0]   rdy_w, so_w, frame_w, done_w, busy_w;

  shift_tx_ctrl #(.WIDTH(W), .DIV(2), .GAP(1)) dut_a (
    .clk(clk), .rst(rst_v[0]), .in_valid(vld[0]), .in_data(dat[0]),
    .in_ready(rdy_w[0]), .so(so_w[0]), .frame(frame_w[0]),
    .done(done_w[0]), .busy(busy_w[0])
  );

  shift_tx_ctrl #(.WIDTH(W), .DIV(1), .GAP(0)) dut_b (
    .clk(clk), .rst(rst_v[1]), .in_valid(vld[1]), .in_data(dat[1]),
    .in_ready(rdy_w[1]), .so(so_w[1]), .frame(frame_w[1]),
    .done(done_w[1]), .busy(busy_w[1])
  );

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;
  logic [1:0] rst_e;

  always @(posedge clk) begin
    ncyc  <= ncyc + 1;
    rst_e <= rst_v;
  end

  // scoreboard: accepted word and the cycle it was accepted in
  logic [W-1:0] exp_w [2][$];
  int           exp_a [2][$];
  logic [W-1:0] words [2][$];
  int           ready_at [2];
  logic [1:0]   rst_req;
  logic [1:0]   noise;
  logic [1:0]   accepted;

  task automatic chk(input string nm, input int d, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d cycle=%0d actual=%0d expected=%0d", nm, d, ncyc, act, exp);
    end
  endtask

  // one clock: check handshake outputs against the model, then drive inputs
  task automatic cycle();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("in_ready", d, int'(rdy_w[d]), int'(ncyc >= ready_at[d]));
      chk("busy", d, int'(busy_w[d]), int'(ncyc < ready_at[d]));
      accepted[d] = 1'b0;
      if (rst_req[d]) begin
        rst_v[d]    = 1'b1;
        vld[d]      = 1'($urandom_range(0, 1));
        dat[d]      = W'($urandom);
        ready_at[d] = ncyc + 1;
        rst_req[d]  = 1'b0;
      end else begin
        rst_v[d] = 1'b0;
        if (words[d].size() > 0) begin
          vld[d] = 1'b1;
          dat[d] = words[d][0];
        end else begin
          vld[d] = noise[d] ? 1'($urandom_range(0, 1)) : 1'b0;
          dat[d] = W'($urandom);
        end
        if (vld[d] && ncyc >= ready_at[d]) begin
          exp_w[d].push_back(dat[d]);
          exp_a[d].push_back(ncyc);
          ready_at[d] = ncyc + (W + gp(d)) * dv(d) + 1;
          if (words[d].size() > 0) void'(words[d].pop_front());
          accepted[d] = 1'b1;
        end
      end
    end
  endtask

  // monitor: collect so while frame is high and score each finished frame
  bit [1:0] coll = '0;
  int       nsmp [2];
  bit       smp  [2][64];

  always @(negedge clk) begin
    int           errs;
    logic [W-1:0] wexp;
    for (int d = 0; d < 2; d++) begin
      if (rst_e[d] === 1'b1) begin
        chk("rst_frame", d, int'(frame_w[d]), 0);
        chk("rst_so", d, int'(so_w[d]), 0);
        chk("rst_done", d, int'(done_w[d]), 0);
        if (coll[d]) begin
          void'(exp_w[d].pop_front());
          void'(exp_a[d].pop_front());
          coll[d] = 1'b0;
        end
      end else if (frame_w[d]) begin
        if (!coll[d]) begin
          coll[d] = 1'b1;
          nsmp[d] = 0;
          chk("frame_start", d, ncyc, (exp_a[d].size() > 0) ? exp_a[d][0] + 1 : -1);
        end
        if (nsmp[d] < 64) smp[d][nsmp[d]] = so_w[d];
        nsmp[d]++;
        chk("done_in_frame", d, int'(done_w[d]), 0);
      end else begin
        chk("so_idle", d, int'(so_w[d]), 0);
        if (coll[d]) begin
          coll[d] = 1'b0;
          chk("done_pulse", d, int'(done_w[d]), 1);
          chk("frame_len", d, nsmp[d], W * dv(d));
          chk("frame_expected", d, int'(exp_w[d].size() > 0), 1);
          if (exp_w[d].size() > 0) begin
            wexp = exp_w[d][0];
            errs = 0;
            for (int i = 0; i < nsmp[d] && i < W * dv(d); i++) begin
              if (smp[d][i] != wexp[W - 1 - i / dv(d)]) errs++;
            end
            chk("frame_bits", d, errs, 0);
            void'(exp_w[d].pop_front());
            void'(exp_a[d].pop_front());
          end
        end else begin
          chk("done_spurious", d, int'(done_w[d]), 0);
        end
      end
    end
  end

  initial begin
    int k;
    rst_v       = 2'b11;
    vld         = 2'b00;
    dat[0]      = '0;
    dat[1]      = '0;
    rst_req     = 2'b00;
    noise       = 2'b00;
    accepted    = 2'b00;
    ready_at[0] = 0;
    ready_at[1] = 0;

    repeat (3) begin
      rst_req = 2'b11;
      cycle();
    end
    repeat (5) cycle();

    // single frames
    words[0].push_back(8'hA5);
    words[1].push_back(8'h3C);
    repeat (25) cycle();

    // valid held high: back-to-back words
    words[0].push_back(8'hFF);
    words[0].push_back(8'h00);
    words[1].push_back(8'h81);
    words[1].push_back(8'h81);
    repeat (45) cycle();

    // reset in cycle 6 of a frame, then a normal word
    words[0].push_back(8'hFF);
    k = 0;
    cycle();
    while (!accepted[0] && k < 60) begin
      cycle();
      k++;
    end
    chk("accept_timeout", 0, int'(accepted[0]), 1);
    repeat (5) cycle();
    rst_req[0] = 1'b1;
    cycle();
    words[0].push_back(8'h5A);
    repeat (40) cycle();

    // random traffic: noisy valid while busy, toggling data, rare resets
    noise = 2'b11;
    for (int i = 0; i < 3000; i++) begin
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(0, 299) == 0) rst_req[d] = 1'b1;
        if ($urandom_range(0, 99) == 0 && words[d].size() < 2)
          words[d].push_back(W'($urandom));
      end
      cycle();
    end

    noise = 2'b00;
    words[0].delete();
    words[1].delete();
    repeat (40) cycle();
    for (int d = 0; d < 2; d++) begin
      chk("drain_queue", d, exp_w[d].size(), 0);
      chk("drain_collect", d, int'(coll[d]), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_tx_ctrl.md
SHIFT_TX_CTRL -- requirements
Module: shift_tx_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning bits per frame (>=2).
REQ-002 The block SHALL have parameter DIV, default 4, meaning clock cycles per bit period (>=1).
REQ-003 The block SHALL have parameter GAP, default 2, meaning idle bit periods between frames (>=0).
REQ-004 Port: clk  input  1  clock; all logic on posedge clk.
REQ-005 Port: rst  input  1  reset, synchronous, active-high.
REQ-006 Port: in_valid  input  1  word offered.
REQ-007 Port: in_data  input  WIDTH  parallel word to serialize.
REQ-008 Port: in_ready  output  1  controller can accept a word.
REQ-009 Port: so  output  1  serial data out, MSB first.
REQ-010 Port: frame  output  1  high while a frame bit is on so.
REQ-011 Port: done  output  1  one-cycle pulse on frame completion.
REQ-012 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT, GAPW; there are no other reachable states.
REQ-014 in_ready SHALL be 1 exactly when state is IDLE, decoded from state only, never from in_valid.
REQ-015 Acceptance SHALL occur on a posedge with in_valid=1 and in_ready=1: load in_data into the WIDTH-bit shift register, clear the bit counter and divider counter, and go IDLE->SHIFT.
REQ-016 in_valid while in_ready=0 SHALL be ignored; in_data changes after acceptance SHALL not affect the frame in progress.
REQ-017 In SHIFT, so SHALL equal shift register MSB and frame SHALL be 1; the first bit SHALL appear in the cycle after acceptance.
REQ-018 The divider SHALL count 0..DIV-1; at DIV-1 it SHALL wrap to 0, the register SHALL shift left with 0 fill, and the bit counter SHALL increment, so each bit is held exactly DIV cycles.
REQ-019 At divider DIV-1 with bit counter WIDTH-1, the FSM SHALL leave SHIFT: to GAPW if GAP>0, else to IDLE.
REQ-020 done SHALL be registered and high for exactly the one cycle after the final SHIFT cycle.
REQ-021 GAPW SHALL last GAP*DIV cycles with so=0 and frame=0, then go to IDLE.
REQ-022 In IDLE, so=0 and frame=0.
REQ-023 busy SHALL be 1 in SHIFT and GAPW and 0 in IDLE.
REQ-024 Accept-to-accept period with in_valid held high SHALL be WIDTH*DIV + GAP*DIV + 1 cycles.
REQ-025 With GAP=0, in_ready SHALL be 1 in the same cycle as done, allowing acceptance on that edge.
REQ-026 Counter widths SHALL be sized with $clog2 so that DIV=1 and WIDTH=2 work without truncation.

Reset
REQ-027 While rst=1 on a posedge: state IDLE, shift register, bit counter and divider cleared, and done=0; in_valid SHALL be ignored in that cycle.
REQ-028 After reset: in_ready=1, so=0, frame=0, busy=0, done=0.
REQ-029 rst asserted mid-frame or mid-gap SHALL abort the frame: so=0 and frame=0 from the next cycle, and no done pulse.

Verification (WIDTH=8, DIV=2, GAP=1 unless stated)
REQ-030 Reset then idle 5 cycles -> in_ready=1, so=0, frame=0, busy=0, done=0 throughout.
REQ-031 Accept 0xA5 at cycle 0 -> so over cycles 1..16 = 1,1,0,0,1,1,0,0,0,0,1,1,0,0,1,1 with frame=1; done=1 in cycle 17 only; in_ready=1 again in cycle 19.
REQ-032 in_valid held high with 0xFF then 0x00 -> second word accepted 19 cycles after the first; in_ready=0 in cycles 1..18; second frame so=0 for 16 cycles with frame=1.
REQ-033 GAP=0, DIV=1, back-to-back 0x81,0x81 -> accepts 9 cycles apart; so=1,0,0,0,0,0,0,1 repeats with no idle cycle between frames except the accept cycle.
REQ-034 rst pulsed in cycle 6 of an 0xFF frame -> so=0, frame=0, busy=0 from cycle 7; no done; next word accepted normally.
REQ-035 in_data toggled every cycle during SHIFT, and in_valid pulsed while busy -> transmitted bits equal the word captured at acceptance; no extra acceptance.
